// File: rtl/ysyx_22050710_axil_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050710_axil_pkg
//
// Purpose : shared types and constants for the AXI4-Lite N-to-1 arbiter slice.
//           Holds the arbiter FSM state encoding, AXI response codes, the
//           default prot value driven when no master owns the bus, and a small
//           one-hot to index helper used to feed the round-robin pointer.
//
// Contents:
//   axil_state_e     arbiter FSM states (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP)
//   axi_resp_e       AXI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   AXI_PROT_DEFAULT prot driven on the slave port while idle
//   MAX_MST          upper bound on the number of masters (8)
//   MST_IDX_WD       width of a master index (enough for MAX_MST)
//   onehot_to_idx    one-hot grant vector to binary master index
// ---------------------------------------------------------------------------
package ysyx_22050710_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } axil_state_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    localparam int MAX_MST    = 8;
    localparam int MST_IDX_WD = 3;

    // Converts a one-hot (or all-zero) vector into the index of its set bit.
    // An all-zero input yields index 0.
    function automatic logic [MST_IDX_WD-1:0] onehot_to_idx(input logic [MAX_MST-1:0] oh);
        logic [MST_IDX_WD-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MST; i++) begin
            if (oh[i]) begin
                idx = MST_IDX_WD'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ysyx_22050710_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22050710_rr_arbiter
//
// Purpose : combinational one-hot grant from a request vector. With
//           YSYX_22050710_AXIL_ARB_RR_EN defined the search starts at a
//           registered priority pointer that moves to one past the winner
//           each time update_i pulses (round-robin). Without the macro the
//           lowest requesting index always wins and no pointer exists.
//
// Configuration macro: YSYX_22050710_AXIL_ARB_RR_EN
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset (pointer returns to 0)
//   req_i      request vector, one bit per master
//   update_i   pulse when the owning transaction completes
//   win_idx_i  index of the master whose transaction just completed
//   grant_o    one-hot grant (all zero when nothing requests)
// ---------------------------------------------------------------------------
module ysyx_22050710_rr_arbiter
    import ysyx_22050710_axil_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic                  update_i,
    input  logic [MST_IDX_WD-1:0] win_idx_i,
    output logic [NUM_REQ-1:0]    grant_o
);

`ifdef YSYX_22050710_AXIL_ARB_RR_EN

    logic [MST_IDX_WD-1:0] ptr_q;
    logic [MST_IDX_WD-1:0] ptr_d;
    logic [MST_IDX_WD:0]   target;
    logic                  found;

    // Walk the masters starting at the pointer, wrapping past NUM_REQ-1.
    // The first requester met along that circular order gets the grant.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        target  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            target = {1'b0, ptr_q} + (MST_IDX_WD+1)'(i);
            if (target >= (MST_IDX_WD+1)'(NUM_REQ)) begin
                target = target - (MST_IDX_WD+1)'(NUM_REQ);
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req_i[k] && (target == (MST_IDX_WD+1)'(k))) begin
                    grant_o[k] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    // The master just served drops to lowest priority next time round.
    assign ptr_d = (win_idx_i == MST_IDX_WD'(NUM_REQ - 1)) ? '0 : win_idx_i + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (update_i) begin
            ptr_q <= ptr_d;
        end
    end

`else

    logic unused_sigs;

    // Isolate the lowest set request bit: lowest index has highest priority.
    assign grant_o = req_i & ~(req_i - 1'b1);

    // Clock, reset and pointer-update inputs only matter in round-robin mode.
    assign unused_sigs = ^{clk_i, rst_ni, update_i, win_idx_i};

`endif

endmodule

// File: rtl/ysyx_22050710_axil_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22050710_axil_arbiter
//
// Purpose : AXI4-Lite N-to-1 arbiter. NUM_MST masters share one AXI4-Lite
//           slave port with exactly one read or write transaction in flight.
//           The owner's channels pass straight through; responses return only
//           to the owner. Arbitration is round-robin when
//           YSYX_22050710_AXIL_ARB_RR_EN is defined, otherwise fixed priority
//           with master 0 (IFU) highest.
//
// Configuration macro: YSYX_22050710_AXIL_ARB_RR_EN
//
// Parameters: NUM_MST (2..8), ADDR_WD, DATA_WD, STRB_WD = DATA_WD/8
//
// Ports (master buses packed, master k occupies slice k):
//   i_aclk, i_arsetn                clock, asynchronous active-low reset
//   i_m_aw*/o_m_awready             master write-address channels
//   i_m_w*/o_m_wready               master write-data channels
//   o_m_bvalid/o_m_bresp/i_m_bready master write-response channels
//   i_m_ar*/o_m_arready             master read-address channels
//   o_m_rvalid/o_m_r*/i_m_rready    master read-data channels
//   o_s_* / i_s_*                   single slave-side AXI4-Lite port
//   o_grant                         one-hot current owner, 0 when idle
// ---------------------------------------------------------------------------
module ysyx_22050710_axil_arbiter
    import ysyx_22050710_axil_pkg::*;
#(
    parameter  int NUM_MST = 2,
    parameter  int ADDR_WD = 32,
    parameter  int DATA_WD = 64,
    localparam int STRB_WD = DATA_WD / 8
) (
    input  logic                         i_aclk,
    input  logic                         i_arsetn,

    input  logic [NUM_MST-1:0]           i_m_awvalid,
    output logic [NUM_MST-1:0]           o_m_awready,
    input  logic [NUM_MST*ADDR_WD-1:0]   i_m_awaddr,
    input  logic [NUM_MST*3-1:0]         i_m_awprot,
    input  logic [NUM_MST-1:0]           i_m_wvalid,
    output logic [NUM_MST-1:0]           o_m_wready,
    input  logic [NUM_MST*DATA_WD-1:0]   i_m_wdata,
    input  logic [NUM_MST*STRB_WD-1:0]   i_m_wstrb,
    output logic [NUM_MST-1:0]           o_m_bvalid,
    input  logic [NUM_MST-1:0]           i_m_bready,
    output logic [NUM_MST*2-1:0]         o_m_bresp,
    input  logic [NUM_MST-1:0]           i_m_arvalid,
    output logic [NUM_MST-1:0]           o_m_arready,
    input  logic [NUM_MST*ADDR_WD-1:0]   i_m_araddr,
    input  logic [NUM_MST*3-1:0]         i_m_arprot,
    output logic [NUM_MST-1:0]           o_m_rvalid,
    input  logic [NUM_MST-1:0]           i_m_rready,
    output logic [NUM_MST*DATA_WD-1:0]   o_m_rdata,
    output logic [NUM_MST*2-1:0]         o_m_rresp,

    output logic                         o_s_awvalid,
    input  logic                         i_s_awready,
    output logic [ADDR_WD-1:0]           o_s_awaddr,
    output logic [2:0]                   o_s_awprot,
    output logic                         o_s_wvalid,
    input  logic                         i_s_wready,
    output logic [DATA_WD-1:0]           o_s_wdata,
    output logic [STRB_WD-1:0]           o_s_wstrb,
    input  logic                         i_s_bvalid,
    output logic                         o_s_bready,
    input  logic [1:0]                   i_s_bresp,
    output logic                         o_s_arvalid,
    input  logic                         i_s_arready,
    output logic [ADDR_WD-1:0]           o_s_araddr,
    output logic [2:0]                   o_s_arprot,
    input  logic                         i_s_rvalid,
    output logic                         o_s_rready,
    input  logic [DATA_WD-1:0]           i_s_rdata,
    input  logic [1:0]                   i_s_rresp,

    output logic [NUM_MST-1:0]           o_grant
);

    axil_state_e           state_q;
    logic [NUM_MST-1:0]    grant_q;
    logic                  awDone_q;
    logic                  wDone_q;

    logic [NUM_MST-1:0]    req;
    logic [NUM_MST-1:0]    arbGrant;
    logic [MST_IDX_WD-1:0] grantIdx;

    logic                  selAwvalid;
    logic                  selWvalid;
    logic                  selArvalid;
    logic                  selRready;
    logic                  selBready;

    logic                  arHs;
    logic                  rHs;
    logic                  awHs;
    logic                  wHs;
    logic                  bHs;
    logic                  txnDone;

    assign req      = i_m_arvalid | i_m_awvalid;
    assign grantIdx = onehot_to_idx(MAX_MST'(grant_q));

    ysyx_22050710_rr_arbiter #(
        .NUM_REQ (NUM_MST)
    ) u_arb (
        .clk_i     (i_aclk),
        .rst_ni    (i_arsetn),
        .req_i     (req),
        .update_i  (txnDone),
        .win_idx_i (grantIdx),
        .grant_o   (arbGrant)
    );

    // Select the owning master's request-side signals. With no owner every
    // selected value is zero, so the slave sees a quiet bus.
    always_comb begin
        selAwvalid = 1'b0;
        selWvalid  = 1'b0;
        selArvalid = 1'b0;
        selRready  = 1'b0;
        selBready  = 1'b0;
        o_s_awaddr = '0;
        o_s_awprot = AXI_PROT_DEFAULT;
        o_s_wdata  = '0;
        o_s_wstrb  = '0;
        o_s_araddr = '0;
        o_s_arprot = AXI_PROT_DEFAULT;
        for (int k = 0; k < NUM_MST; k++) begin
            if (grant_q[k]) begin
                selAwvalid = i_m_awvalid[k];
                selWvalid  = i_m_wvalid[k];
                selArvalid = i_m_arvalid[k];
                selRready  = i_m_rready[k];
                selBready  = i_m_bready[k];
                o_s_awaddr = i_m_awaddr[k*ADDR_WD +: ADDR_WD];
                o_s_awprot = i_m_awprot[k*3 +: 3];
                o_s_wdata  = i_m_wdata[k*DATA_WD +: DATA_WD];
                o_s_wstrb  = i_m_wstrb[k*STRB_WD +: STRB_WD];
                o_s_araddr = i_m_araddr[k*ADDR_WD +: ADDR_WD];
                o_s_arprot = i_m_arprot[k*3 +: 3];
            end
        end
    end

    // Valid/ready routing is gated by state so only the channel belonging to
    // the current phase is open. In WR_REQ a finished channel is closed via
    // its done flag so a master that still holds valid cannot issue twice.
    always_comb begin
        o_m_awready = '0;
        o_m_wready  = '0;
        o_m_bvalid  = '0;
        o_m_arready = '0;
        o_m_rvalid  = '0;
        o_s_awvalid = 1'b0;
        o_s_wvalid  = 1'b0;
        o_s_bready  = 1'b0;
        o_s_arvalid = 1'b0;
        o_s_rready  = 1'b0;
        unique case (state_q)
            ST_RD_ADDR: begin
                o_s_arvalid = selArvalid;
                if (i_s_arready) begin
                    o_m_arready = grant_q;
                end
            end
            ST_RD_DATA: begin
                o_s_rready = selRready;
                if (i_s_rvalid) begin
                    o_m_rvalid = grant_q;
                end
            end
            ST_WR_REQ: begin
                o_s_awvalid = selAwvalid & ~awDone_q;
                o_s_wvalid  = selWvalid & ~wDone_q;
                if (i_s_awready && !awDone_q) begin
                    o_m_awready = grant_q;
                end
                if (i_s_wready && !wDone_q) begin
                    o_m_wready = grant_q;
                end
            end
            ST_WR_RESP: begin
                o_s_bready = selBready;
                if (i_s_bvalid) begin
                    o_m_bvalid = grant_q;
                end
            end
            default: begin
            end
        endcase
    end

    assign arHs    = o_s_arvalid & i_s_arready;
    assign rHs     = (state_q == ST_RD_DATA) & i_s_rvalid & selRready;
    assign awHs    = o_s_awvalid & i_s_awready;
    assign wHs     = o_s_wvalid & i_s_wready;
    assign bHs     = (state_q == ST_WR_RESP) & i_s_bvalid & selBready;
    assign txnDone = rHs | bHs;

    // Response payloads are broadcast; only the owner sees a valid.
    assign o_m_rdata = {NUM_MST{i_s_rdata}};
    assign o_m_rresp = {NUM_MST{i_s_rresp}};
    assign o_m_bresp = {NUM_MST{i_s_bresp}};
    assign o_grant   = grant_q;

    // Transaction FSM. The winner's arvalid decides the operation, so a
    // master raising arvalid and awvalid together gets its read first and
    // its write in a later arbitration round.
    always_ff @(posedge i_aclk or negedge i_arsetn) begin
        if (!i_arsetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q <= arbGrant;
                        state_q <= (|(arbGrant & i_m_arvalid)) ? ST_RD_ADDR : ST_WR_REQ;
                    end
                end
                ST_RD_ADDR: begin
                    if (arHs) begin
                        state_q <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rHs) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                    end
                end
                ST_WR_REQ: begin
                    if ((awDone_q || awHs) && (wDone_q || wHs)) begin
                        state_q  <= ST_WR_RESP;
                        awDone_q <= 1'b0;
                        wDone_q  <= 1'b0;
                    end else begin
                        if (awHs) begin
                            awDone_q <= 1'b1;
                        end
                        if (wHs) begin
                            wDone_q <= 1'b1;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (bHs) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_axil_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050710_axil_arbiter
//
// Directed bench for the AXI4-Lite arbiter with two masters. Single reads
// come from a vector table; writes, arbitration order, dual AR/AW requests,
// read back-pressure and mid-transaction reset are hand-written sequences.
// Expected arbitration order follows YSYX_22050710_AXIL_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_ysyx_22050710_axil_arbiter;
    import ysyx_22050710_axil_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    typedef struct {
        int          mst;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [63:0] data;
        logic [1:0]  resp;
        logic [1:0]  expGrant;
    } readVec_t;

    logic clk = 1'b0;
    logic rstn;

    logic [N-1:0]    mAwvalid, mAwready, mWvalid, mWready, mBvalid, mBready;
    logic [N-1:0]    mArvalid, mArready, mRvalid, mRready;
    logic [N*AW-1:0] mAwaddr, mAraddr;
    logic [N*3-1:0]  mAwprot, mArprot;
    logic [N*DW-1:0] mWdata, mRdata;
    logic [N*SW-1:0] mWstrb;
    logic [N*2-1:0]  mBresp, mRresp;

    logic          sAwvalid, sAwready, sWvalid, sWready, sBvalid, sBready;
    logic          sArvalid, sArready, sRvalid, sRready;
    logic [AW-1:0] sAwaddr, sAraddr;
    logic [2:0]    sAwprot, sArprot;
    logic [DW-1:0] sWdata, sRdata;
    logic [SW-1:0] sWstrb;
    logic [1:0]    sBresp, sRresp;
    logic [N-1:0]  oGrant;

    int testCount = 0;
    int failCount = 0;
    int awHsCount = 0;
    int wHsCount  = 0;

    readVec_t   readVecs[4];
    logic [1:0] expSeq[4];

    ysyx_22050710_axil_arbiter #(
        .NUM_MST (N),
        .ADDR_WD (AW),
        .DATA_WD (DW)
    ) dut (
        .i_aclk      (clk),
        .i_arsetn    (rstn),
        .i_m_awvalid (mAwvalid),
        .o_m_awready (mAwready),
        .i_m_awaddr  (mAwaddr),
        .i_m_awprot  (mAwprot),
        .i_m_wvalid  (mWvalid),
        .o_m_wready  (mWready),
        .i_m_wdata   (mWdata),
        .i_m_wstrb   (mWstrb),
        .o_m_bvalid  (mBvalid),
        .i_m_bready  (mBready),
        .o_m_bresp   (mBresp),
        .i_m_arvalid (mArvalid),
        .o_m_arready (mArready),
        .i_m_araddr  (mAraddr),
        .i_m_arprot  (mArprot),
        .o_m_rvalid  (mRvalid),
        .i_m_rready  (mRready),
        .o_m_rdata   (mRdata),
        .o_m_rresp   (mRresp),
        .o_s_awvalid (sAwvalid),
        .i_s_awready (sAwready),
        .o_s_awaddr  (sAwaddr),
        .o_s_awprot  (sAwprot),
        .o_s_wvalid  (sWvalid),
        .i_s_wready  (sWready),
        .o_s_wdata   (sWdata),
        .o_s_wstrb   (sWstrb),
        .i_s_bvalid  (sBvalid),
        .o_s_bready  (sBready),
        .i_s_bresp   (sBresp),
        .o_s_arvalid (sArvalid),
        .i_s_arready (sArready),
        .o_s_araddr  (sAraddr),
        .o_s_arprot  (sArprot),
        .i_s_rvalid  (sRvalid),
        .o_s_rready  (sRready),
        .i_s_rdata   (sRdata),
        .i_s_rresp   (sRresp),
        .o_grant     (oGrant)
    );

    always #5 clk = ~clk;

    // Count slave-side address and data handshakes for the write sequence.
    always @(posedge clk) begin
        if (sAwvalid && sAwready) awHsCount <= awHsCount + 1;
        if (sWvalid && sWready)   wHsCount  <= wHsCount + 1;
    end

    // Hard stop in case a sequence wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic clearInputs();
        mAwvalid = '0; mAwaddr = '0; mAwprot = '0;
        mWvalid  = '0; mWdata  = '0; mWstrb  = '0;
        mBready  = '0;
        mArvalid = '0; mAraddr = '0; mArprot = '0;
        mRready  = '0;
        sAwready = 1'b0; sWready = 1'b0;
        sBvalid  = 1'b0; sBresp  = 2'b00;
        sArready = 1'b0;
        sRvalid  = 1'b0; sRdata  = '0; sRresp = 2'b00;
    endtask

    task automatic applyReset();
        clearInputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // One read by a single master against a zero-wait slave.
    task automatic applyStimulus(input readVec_t v);
        mArvalid[v.mst]             = 1'b1;
        mAraddr[v.mst*AW +: AW]     = v.addr;
        mArprot[v.mst*3 +: 3]       = v.prot;
        #1;
        checkOutput("rd_idle_grant", 64'(oGrant), 64'd0);
        tick();
        checkOutput("rd_grant", 64'(oGrant), 64'(v.expGrant));
        checkOutput("rd_s_arvalid", 64'(sArvalid), 64'd1);
        checkOutput("rd_s_araddr", 64'(sAraddr), 64'(v.addr));
        checkOutput("rd_s_arprot", 64'(sArprot), 64'(v.prot));
        sArready = 1'b1;
        #1;
        checkOutput("rd_m_arready", 64'(mArready), 64'(v.expGrant));
        tick();
        mArvalid[v.mst]     = 1'b0;
        sArready            = 1'b0;
        sRvalid             = 1'b1;
        sRdata              = v.data;
        sRresp              = v.resp;
        mRready[v.mst]      = 1'b1;
        #1;
        checkOutput("rd_m_rvalid", 64'(mRvalid), 64'(v.expGrant));
        checkOutput("rd_m_rdata", mRdata[v.mst*DW +: DW], v.data);
        checkOutput("rd_m_rresp", 64'(mRresp[v.mst*2 +: 2]), 64'(v.resp));
        checkOutput("rd_s_rready", 64'(sRready), 64'd1);
        tick();
        sRvalid = 1'b0;
        mRready = '0;
        #1;
        checkOutput("rd_grant_clear", 64'(oGrant), 64'd0);
    endtask

    initial begin
        readVecs[0] = '{1, 32'h8000_0010, 3'b000, 64'hDEAD_BEEF_0000_0001, 2'b00, 2'b10};
        readVecs[1] = '{0, 32'h8000_0000, 3'b100, 64'h0123_4567_89AB_CDEF, 2'b00, 2'b01};
        readVecs[2] = '{1, 32'h8000_0020, 3'b001, 64'hFFFF_0000_AAAA_5555, 2'b10, 2'b10};
        readVecs[3] = '{0, 32'h8000_0008, 3'b010, 64'h1357_9BDF_2468_ACE0, 2'b10, 2'b01};
`ifdef YSYX_22050710_AXIL_ARB_RR_EN
        expSeq[0] = 2'b01; expSeq[1] = 2'b10; expSeq[2] = 2'b01; expSeq[3] = 2'b10;
`else
        expSeq[0] = 2'b01; expSeq[1] = 2'b01; expSeq[2] = 2'b01; expSeq[3] = 2'b01;
`endif

        // Reset state: slave valids held high must not leak to any master.
        clearInputs();
        rstn     = 1'b0;
        sRvalid  = 1'b1;
        sBvalid  = 1'b1;
        sArready = 1'b1;
        sAwready = 1'b1;
        tick();
        checkOutput("reset_grant", 64'(oGrant), 64'd0);
        checkOutput("reset_m_rvalid", 64'(mRvalid), 64'd0);
        checkOutput("reset_m_bvalid", 64'(mBvalid), 64'd0);
        checkOutput("reset_m_arready", 64'(mArready), 64'd0);
        checkOutput("reset_m_awready", 64'(mAwready), 64'd0);
        checkOutput("reset_s_valids", 64'({sArvalid, sAwvalid, sWvalid, sRready, sBready}), 64'd0);
        applyReset();

        // Table of single reads.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(readVecs[i]);
        end

        // Write by master 1; slave takes W two cycles after AW.
        awHsCount = 0;
        wHsCount  = 0;
        mAwvalid[1]         = 1'b1;
        mAwaddr[AW +: AW]   = 32'h8000_0100;
        mAwprot[3 +: 3]     = 3'b001;
        mWvalid[1]          = 1'b1;
        mWdata[DW +: DW]    = 64'hCAFE_F00D_1234_5678;
        mWstrb[SW +: SW]    = 8'h0F;
        tick();
        checkOutput("wr_grant", 64'(oGrant), 64'h2);
        checkOutput("wr_s_awvalid", 64'(sAwvalid), 64'd1);
        checkOutput("wr_s_awaddr", 64'(sAwaddr), 64'h8000_0100);
        checkOutput("wr_s_awprot", 64'(sAwprot), 64'h1);
        checkOutput("wr_s_wvalid", 64'(sWvalid), 64'd1);
        checkOutput("wr_s_wdata", sWdata, 64'hCAFE_F00D_1234_5678);
        checkOutput("wr_s_wstrb", 64'(sWstrb), 64'h0F);
        checkOutput("wr_s_arvalid", 64'(sArvalid), 64'd0);
        sAwready = 1'b1;
        #1;
        checkOutput("wr_m_awready", 64'(mAwready), 64'h2);
        checkOutput("wr_m_wready_early", 64'(mWready), 64'd0);
        tick();
        checkOutput("wr_aw_suppressed", 64'(sAwvalid), 64'd0);
        checkOutput("wr_m_awready_after", 64'(mAwready), 64'd0);
        checkOutput("wr_s_wvalid_held", 64'(sWvalid), 64'd1);
        tick();
        mAwvalid[1] = 1'b0;
        sAwready    = 1'b0;
        sWready     = 1'b1;
        #1;
        checkOutput("wr_m_wready", 64'(mWready), 64'h2);
        tick();
        mWvalid[1] = 1'b0;
        sWready    = 1'b0;
        sBvalid    = 1'b1;
        sBresp     = 2'b00;
        mBready[1] = 1'b1;
        #1;
        checkOutput("wr_m_bvalid", 64'(mBvalid), 64'h2);
        checkOutput("wr_m_bresp", 64'(mBresp[3:2]), 64'd0);
        checkOutput("wr_s_bready", 64'(sBready), 64'd1);
        checkOutput("wr_s_wvalid_done", 64'(sWvalid), 64'd0);
        tick();
        sBvalid = 1'b0;
        mBready = '0;
        #1;
        checkOutput("wr_grant_clear", 64'(oGrant), 64'd0);
        checkOutput("wr_aw_count", 64'(awHsCount), 64'd1);
        checkOutput("wr_w_count", 64'(wHsCount), 64'd1);

        // Both masters read continuously from a fresh pointer.
        applyReset();
        mArvalid = 2'b11;
        mAraddr  = {32'h8000_1000, 32'h8000_0000};
        mRready  = 2'b11;
        sArready = 1'b1;
        sRvalid  = 1'b1;
        sRdata   = 64'hA5A5_A5A5_5A5A_5A5A;
        for (int t = 0; t < 4; t++) begin
            int budget;
            budget = 0;
            while (oGrant == '0 && budget < 10) begin
                tick();
                budget++;
            end
            checkOutput($sformatf("rr_grant%0d", t), 64'(oGrant), 64'(expSeq[t]));
            budget = 0;
            while (oGrant != '0 && budget < 10) begin
                tick();
                budget++;
            end
            checkOutput($sformatf("rr_release%0d", t), 64'(oGrant), 64'd0);
        end
        clearInputs();
        tick();

        // Master 0 raises arvalid and awvalid together: read first.
        mArvalid[0]       = 1'b1;
        mAwvalid[0]       = 1'b1;
        mWvalid[0]        = 1'b1;
        mAraddr[0 +: AW]  = 32'h8000_2000;
        mAwaddr[0 +: AW]  = 32'h8000_3000;
        mWdata[0 +: DW]   = 64'h0000_0000_0000_00FF;
        mWstrb[0 +: SW]   = 8'hFF;
        mRready[0]        = 1'b1;
        mBready[0]        = 1'b1;
        sArready = 1'b1; sRvalid = 1'b1;
        sAwready = 1'b1; sWready = 1'b1; sBvalid = 1'b1;
        tick();
        checkOutput("dual_grant_rd", 64'(oGrant), 64'h1);
        checkOutput("dual_s_arvalid", 64'(sArvalid), 64'd1);
        checkOutput("dual_s_awvalid_rd", 64'(sAwvalid), 64'd0);
        tick();
        mArvalid[0] = 1'b0;
        #1;
        checkOutput("dual_m_rvalid", 64'(mRvalid), 64'h1);
        tick();
        checkOutput("dual_bubble", 64'(oGrant), 64'd0);
        tick();
        checkOutput("dual_grant_wr", 64'(oGrant), 64'h1);
        checkOutput("dual_s_awvalid", 64'(sAwvalid), 64'd1);
        checkOutput("dual_s_awaddr", 64'(sAwaddr), 64'h8000_3000);
        checkOutput("dual_s_arvalid_wr", 64'(sArvalid), 64'd0);
        tick();
        mAwvalid[0] = 1'b0;
        mWvalid[0]  = 1'b0;
        #1;
        checkOutput("dual_m_bvalid", 64'(mBvalid), 64'h1);
        tick();
        clearInputs();
        #1;
        checkOutput("dual_done", 64'(oGrant), 64'd0);

        // Read back-pressure: rready low for 5 cycles with master 1 waiting.
        mArvalid[0]      = 1'b1;
        mAraddr[0 +: AW] = 32'h8000_4000;
        tick();
        sArready = 1'b1;
        tick();
        mArvalid[0] = 1'b0;
        sArready    = 1'b0;
        mArvalid[1] = 1'b1;
        mAraddr[AW +: AW] = 32'h8000_5000;
        sRvalid     = 1'b1;
        sRdata      = 64'h1111_2222_3333_4444;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("bp_rvalid%0d", c), 64'(mRvalid), 64'h1);
            checkOutput($sformatf("bp_rdata%0d", c), mRdata[0 +: DW], 64'h1111_2222_3333_4444);
            checkOutput($sformatf("bp_grant%0d", c), 64'(oGrant), 64'h1);
            tick();
        end
        mRready[0] = 1'b1;
        #1;
        checkOutput("bp_s_rready", 64'(sRready), 64'd1);
        tick();
        sRvalid = 1'b0;
        mRready = '0;
        #1;
        checkOutput("bp_release", 64'(oGrant), 64'd0);
        tick();
        checkOutput("bp_next_grant", 64'(oGrant), 64'h2);
        sArready = 1'b1;
        tick();
        mArvalid[1] = 1'b0;
        sArready    = 1'b0;
        sRvalid     = 1'b1;
        mRready[1]  = 1'b1;
        tick();
        clearInputs();
        tick();

        // Master 0 completes a read, moving a round-robin pointer to 1.
        applyStimulus(readVecs[1]);

        // Reset in RD_DATA of a master 1 read.
        mArvalid[1]       = 1'b1;
        mAraddr[AW +: AW] = 32'h8000_6000;
        tick();
        sArready = 1'b1;
        tick();
        mArvalid[1] = 1'b0;
        sArready    = 1'b0;
        sRvalid     = 1'b1;
        mRready[1]  = 1'b1;
        #1;
        checkOutput("rst_pre_rvalid", 64'(mRvalid), 64'h2);
        checkOutput("rst_pre_s_rready", 64'(sRready), 64'd1);
        rstn = 1'b0;
        #1;
        checkOutput("rst_grant", 64'(oGrant), 64'd0);
        checkOutput("rst_m_rvalid", 64'(mRvalid), 64'd0);
        checkOutput("rst_s_rready", 64'(sRready), 64'd0);
        clearInputs();
        tick();
        rstn = 1'b1;
        tick();
        mArvalid = 2'b11;
        tick();
        checkOutput("rst_ptr_grant", 64'(oGrant), 64'h1);
        clearInputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_axil_arbiter.md
# ysyx_22050710_axil_arbiter

Parametrised AXI4-Lite N-to-1 arbiter that lets NUM_MST CPU-side masters (IFU, LSU, later DMA/debug) share one AXI4-Lite slave port, replacing the fixed one-master-per-SRAM wiring at SoC top. Exactly one transaction (read or write) is in flight at a time. The granted master's channels pass through to the slave; responses return only to that master. Arbitration is round-robin or fixed-priority (compile-time).

## Interface
Parameters:
- NUM_MST, 2, number of masters (2..8); index 0 = IFU, 1 = LSU
- ADDR_WD, 32, address width
- DATA_WD, 64, data width; STRB_WD = DATA_WD/8 derived

Ports (master-side buses packed, master k occupies slice k):
- i_aclk  in  1  clock
- i_arsetn  in  1  asynchronous active-low reset
- i_m_awvalid / o_m_awready  in/out  NUM_MST  write-address handshake
- i_m_awaddr, i_m_awprot  in  NUM_MST*ADDR_WD, NUM_MST*3  write address, prot
- i_m_wvalid / o_m_wready  in/out  NUM_MST  write-data handshake
- i_m_wdata, i_m_wstrb  in  NUM_MST*DATA_WD, NUM_MST*STRB_WD  write data, strobe
- o_m_bvalid / i_m_bready  out/in  NUM_MST  write-response handshake
- o_m_bresp  out  NUM_MST*2  write response (broadcast, qualified by bvalid)
- i_m_arvalid / o_m_arready  in/out  NUM_MST  read-address handshake
- i_m_araddr, i_m_arprot  in  NUM_MST*ADDR_WD, NUM_MST*3  read address, prot
- o_m_rvalid / i_m_rready  out/in  NUM_MST  read-data handshake
- o_m_rdata, o_m_rresp  out  NUM_MST*DATA_WD, NUM_MST*2  read data, resp (broadcast)
- o_s_aw*/o_s_w*/i_s_b*/o_s_ar*/i_s_r*  slave-side AXI4-Lite port, same names/widths as one master slice, directions mirrored
- o_grant  out  NUM_MST  one-hot current owner, 0 when idle

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- Request of master k: req[k] = arvalid[k] | awvalid[k].
- IDLE: if any req, pick winner, register one-hot grant, latch op = read if winner's arvalid else write. Go RD_ADDR or WR_REQ.
- RD_ADDR: o_s_arvalid = granted arvalid, addr/prot muxed; o_m_arready[g] = i_s_arready. On AR handshake -> RD_DATA.
- RD_DATA: o_m_rvalid[g] = i_s_rvalid, o_s_rready = i_m_rready[g]. On R handshake -> IDLE, grant cleared.
- WR_REQ: AW and W forwarded independently; aw_done/w_done flags set on each handshake and suppress that channel's valid afterwards. Both done (same or different cycles) -> WR_RESP.
- WR_RESP: B routed to owner; on B handshake -> IDLE.
- Non-granted masters: all ready/valid outputs 0.
- Round-robin: priority pointer = one past last winner, updated when a transaction completes; no master waits more than NUM_MST-1 transactions.
- Master asserting arvalid and awvalid together: read served first; write wins a later arbitration.
- rresp/bresp passed unchanged (no decode errors generated here).

## Timing
- Reset (async assert, sync-deasserted upstream): state IDLE, grant 0, pointer 0, aw_done/w_done 0, all valid/ready outputs 0.
- Arbitration latency: 1 cycle (request seen in IDLE, slave valid asserted next cycle).
- Minimum read: 3 cycles request-to-rdata with zero-wait slave; back-to-back transactions have one IDLE bubble.
- Slave-side valids never drop before handshake once asserted (AXI rule); masters must hold valid likewise.
- Reset mid-transaction: all outputs return to 0 immediately; slave in-flight state is the slave's responsibility (shares reset).

## Configuration
- YSYX_22050710_AXIL_ARB_RR_EN defined: round-robin as above.
- Undefined: fixed priority, lowest index wins (IFU highest); pointer logic removed.

## Structure
- Shared package ysyx_22050710_axil_pkg: FSM state typedef, AXI resp codes (OKAY=2'b00, SLVERR=2'b10), prot default.
- Sub-module ysyx_22050710_rr_arbiter: combinational one-hot grant from req vector and pointer, pointer register with update strobe; fixed-priority mode selected inside it by the macro.

## Test plan
- Single read, master 1, araddr=0x8000_0010, slave returns 0xDEAD_BEEF_0000_0001 OKAY -> only o_m_rvalid[1] pulses with that data; o_grant 2'b10 then 0.
- Both masters read continuously (RR) -> grants alternate 0,1,0,1; with macro off master 0 always wins.
- Write with slave accepting W two cycles after AW -> single AW and W handshake each, B OKAY to owner only, then IDLE.
- Master 0 asserts arvalid and awvalid same cycle -> read completes first, write granted in a later arbitration.
- Slave holds rvalid with i_m_rready low 5 cycles -> rdata stable, no new grant until R handshake.
- i_arsetn low during RD_DATA -> all outputs 0 asynchronously, next request after release granted from pointer 0.
